// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_hazard_sequencer_pkg;

    // Sequencer states; encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        SEQ_RUN    = 2'd0,
        SEQ_HALT   = 2'd1,
        SEQ_RESUME = 2'd2
    } seq_state_t;

    localparam int CNT_W_DEF       = 32;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pipeline_hazard_sequencer_sync_edge_detect.sv
// Synchronises an asynchronous level and flags its rising edge.
// Latency: d rising before edge t -> rise high for one cycle after SYNC_STAGES edges.
// Backpressure: none; rise is a single-cycle pulse.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   go_prev;

    // Shift the async level through the synchroniser and remember the last synced value.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync    <= '0;
            go_prev <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], d};
            go_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~go_prev;

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush/halt sequencer for the 5-stage pipeline, with per-cause cycle counters.
// Latency: enables are combinational from state and inputs; halted and counters are registered.
// Backpressure: stalls hold PC and IF_ID and bubble ID_EX; HALT freezes all until a fresh Go edge.
module pipeline_hazard_sequencer
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             go,
    input  logic             conflict,
    input  logic             branch_ex,
    input  logic             jmp_ex,
    input  logic             syscall_ex,
    input  logic             halt_req_ex,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] halt_cnt
);

    seq_state_t state;
    seq_state_t state_nxt;
    logic       go_rise;
    logic       flush;
    logic       stall;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_go_sync (
        .clk (clk),
        .clr (clr),
        .d   (go),
        .rise(go_rise)
    );

    // A syscall outranks a control transfer, which in turn hides any RAW conflict.
    assign flush = (branch_ex | jmp_ex) & ~syscall_ex;
    assign stall = conflict & ~flush & ~syscall_ex;

    // Enable decode and next-state; enables are forced low while reset is asserted.
    always_comb begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        state_nxt = state;
        if (clr) begin
            case (state)
                SEQ_RUN: begin
                    if (syscall_ex) begin
                        // Display service lets the syscall advance once; halt freezes everything.
                        id_ex_en = ~halt_req_ex;
                        if (halt_req_ex) begin
                            state_nxt = SEQ_HALT;
                        end
                    end else if (flush) begin
                        pc_en = 1'b1;
                    end else if (!stall) begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        id_ex_en = 1'b1;
                    end
                end
                SEQ_HALT: begin
                    if (go_rise) begin
                        state_nxt = SEQ_RESUME;
                    end
                end
                SEQ_RESUME: begin
                    // IF_ID still holds a stale slot, so bubble ID_EX for this one cycle.
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    state_nxt = SEQ_RUN;
                end
                default: state_nxt = SEQ_RUN;
            endcase
        end
    end

    // State register, registered halted flag and the three saturating event counters.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= SEQ_RUN;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            halt_cnt  <= '0;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == SEQ_HALT);
            if (state == SEQ_RUN && stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (state == SEQ_RUN && flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
            if (state == SEQ_HALT) begin
                halt_cnt <= sat_inc(halt_cnt);
            end
        end
    end

endmodule
